in_fifo: RTL and testbench

- Host-to-FPGA counterpart of the SRAM-backed output FIFO.
- Accepts a byte stream from the USB side and packs each group of 4 bytes MSB-first into a 32-bit word.
- Buffers words in an internal circular memory and presents them to a downstream consumer through a first-word-fall-through FIFO read interface.
- Status and error counters are exposed on the 8-bit bus with the same register layout style as the output FIFO.

---
 rtl/in_fifo_pkg.sv | 20 ++
 rtl/in_fifo_buf.sv | 74 +++++++
 rtl/in_fifo.sv | 125 ++++++++++++
 tb/tb_in_fifo.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/in_fifo_pkg.sv
// Shared definitions for the USB-to-FPGA input FIFO: register map and
// overflow counter saturation helper.
package in_fifo_pkg;

  // Register addresses on the 8-bit bus
  localparam logic [15:0] ADDR_RST   = 16'd0;
  localparam logic [15:0] ADDR_SIZE0 = 16'd1;
  localparam logic [15:0] ADDR_SIZE1 = 16'd2;
  localparam logic [15:0] ADDR_SIZE2 = 16'd3;
  localparam logic [15:0] ADDR_OVF   = 16'd4;
  localparam logic [15:0] ADDR_BCNT  = 16'd5;

  // Overflow counter sticks here instead of wrapping back to zero
  localparam logic [7:0] OVF_SAT = 8'hFF;

  function automatic logic [7:0] ovf_inc(input logic [7:0] value);
    return (value == OVF_SAT) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/in_fifo_buf.sv
// Single-clock circular word buffer with first-word-fall-through read port.
// A pop on a full buffer frees its slot in the same cycle, so a coincident
// write is accepted.
module in_fifo_buf #(
  parameter int DEPTH = 1024,
  parameter int ABITS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [31:0]      wr_data,
  input  logic             rd_en,
  output logic [31:0]      rd_data,
  output logic [ABITS:0]   count,
  output logic             empty,
  output logic             full
);

  localparam logic [ABITS:0]   CNT_FULL = (ABITS + 1)'(DEPTH);
  localparam logic [ABITS:0]   CNT_ONE  = (ABITS + 1)'(1);
  localparam logic [ABITS-1:0] PTR_ONE  = ABITS'(1);

  logic [31:0]      mem [DEPTH];
  logic [ABITS-1:0] wr_ptr;
  logic [ABITS-1:0] rd_ptr;
  logic [ABITS:0]   count_q;
  logic [ABITS:0]   count_nxt;
  logic             full_q;
  logic             rd_ok;
  logic             wr_ok;

  assign rd_ok = rd_en && (count_q != '0);
  assign wr_ok = wr_en && ((count_q != CNT_FULL) || rd_ok);

  // Next occupancy from the accepted write/read pair
  always_comb begin
    count_nxt = count_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count_q + CNT_ONE;
      2'b01:   count_nxt = count_q - CNT_ONE;
      default: count_nxt = count_q;
    endcase
  end

  // Pointers, occupancy and registered full flag
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop in
    // this block samples the pre-edge values of its neighbours.
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
      count_q <= count_nxt;
      full_q  <= (count_nxt == CNT_FULL);
    end
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; clearing it would prevent RAM inference,
    // and stale words are unreachable once the pointers are reset.
    if (wr_ok && !rst) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign count   = count_q;
  assign empty   = (count_q == '0);
  assign full    = full_q;

endmodule

// File: rtl/in_fifo.sv
// Host-to-FPGA input FIFO: packs USB bytes MSB-first into 32-bit words,
// buffers them, and exposes status/overflow registers on the 8-bit bus.
module in_fifo
  import in_fifo_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int ABITS = 10
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST_N,
  input  logic [15:0] BUS_ADD,
  input  logic [7:0]  BUS_DATA_IN,
  input  logic        BUS_RD,
  input  logic        BUS_WR,
  output logic [7:0]  BUS_DATA_OUT,
  input  logic        USB_WRITE,
  input  logic [7:0]  USB_DATA_IN,
  output logic        USB_FULL,
  input  logic        FIFO_READ_NEXT,
  output logic        FIFO_EMPTY,
  output logic [31:0] FIFO_DATA,
  output logic        FIFO_OVERFLOW
);

  logic           soft_rst;
  logic           RST;
  logic [1:0]     byte_cnt;
  logic [23:0]    shreg;       // bytes 0..2 of the word being assembled
  logic           commit;
  logic [31:0]    commit_word;
  logic           drop;
  logic [7:0]     ovf_cnt;
  logic [ABITS:0] count;
  logic           buf_empty;
  logic           buf_full;
  logic [23:0]    count_ext;
  logic [7:0]     reg_mux;
  logic [7:0]     bus_data_q;
  logic           unused_data_in;

  // Only the strobe of a write matters; the data byte is deliberately ignored
  assign unused_data_in = ^BUS_DATA_IN;

  // One-cycle soft reset pulse following a write to address 0
  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) soft_rst <= 1'b0;
    else            soft_rst <= BUS_WR && (BUS_ADD == ADDR_RST);
  end

  assign RST = !BUS_RST_N || soft_rst;

  // Byte position within the word; a reset discards any partial word
  always_ff @(posedge BUS_CLK) begin
    if (RST)            byte_cnt <= 2'd0;
    else if (USB_WRITE) byte_cnt <= byte_cnt + 2'd1;
  end

  // Capture the first three bytes of each word, MSB first
  always_ff @(posedge BUS_CLK) begin
    if (USB_WRITE && !RST) begin
      unique case (byte_cnt)
        2'd0:    shreg[23:16] <= USB_DATA_IN;
        2'd1:    shreg[15:8]  <= USB_DATA_IN;
        2'd2:    shreg[7:0]   <= USB_DATA_IN;
        default: ;
      endcase
    end
  end

  // The fourth byte goes straight into the committed word
  assign commit      = USB_WRITE && (byte_cnt == 2'd3) && !RST;
  assign commit_word = {shreg, USB_DATA_IN};

  // A commit is lost only when full and no pop frees a slot this cycle
  assign drop = commit && buf_full && !FIFO_READ_NEXT;

  // Saturating count of dropped words
  always_ff @(posedge BUS_CLK) begin
    if (RST)       ovf_cnt <= 8'd0;
    else if (drop) ovf_cnt <= ovf_inc(ovf_cnt);
  end

  in_fifo_buf #(
    .DEPTH (DEPTH),
    .ABITS (ABITS)
  ) u_buf (
    .clk     (BUS_CLK),
    .rst     (RST),
    .wr_en   (commit),
    .wr_data (commit_word),
    .rd_en   (FIFO_READ_NEXT),
    .rd_data (FIFO_DATA),
    .count   (count),
    .empty   (buf_empty),
    .full    (buf_full)
  );

  assign count_ext = 24'(count);

  // Register read decode
  always_comb begin
    // NOTE: default first so every path assigns reg_mux and no latch forms.
    reg_mux = 8'h00;
    unique case (BUS_ADD)
      ADDR_SIZE0: reg_mux = count_ext[7:0];
      ADDR_SIZE1: reg_mux = count_ext[15:8];
      ADDR_SIZE2: reg_mux = count_ext[23:16];
      ADDR_OVF:   reg_mux = ovf_cnt;
      ADDR_BCNT:  reg_mux = {6'b0, byte_cnt};
      default:    reg_mux = 8'h00;
    endcase
  end

  // Registered read data, one cycle after the read strobe
  always_ff @(posedge BUS_CLK) begin
    if (RST)         bus_data_q <= 8'h00;
    else if (BUS_RD) bus_data_q <= reg_mux;
  end

  assign BUS_DATA_OUT  = bus_data_q;
  assign USB_FULL      = buf_full;
  assign FIFO_EMPTY    = buf_empty;
  assign FIFO_OVERFLOW = (ovf_cnt != 8'd0);

endmodule

// File: tb/tb_in_fifo.sv
// Self-checking bench for in_fifo with a 4-word buffer.
module tb_in_fifo;

  localparam int DEPTH = 4;
  localparam int ABITS = 2;

  logic        BUS_CLK;
  logic        BUS_RST_N;
  logic [15:0] BUS_ADD;
  logic [7:0]  BUS_DATA_IN;
  logic        BUS_RD;
  logic        BUS_WR;
  logic [7:0]  BUS_DATA_OUT;
  logic        USB_WRITE;
  logic [7:0]  USB_DATA_IN;
  logic        USB_FULL;
  logic        FIFO_READ_NEXT;
  logic        FIFO_EMPTY;
  logic [31:0] FIFO_DATA;
  logic        FIFO_OVERFLOW;

  int n_checks = 0;
  int n_errors = 0;

  in_fifo #(.DEPTH(DEPTH), .ABITS(ABITS)) dut (
    .BUS_CLK        (BUS_CLK),
    .BUS_RST_N      (BUS_RST_N),
    .BUS_ADD        (BUS_ADD),
    .BUS_DATA_IN    (BUS_DATA_IN),
    .BUS_RD         (BUS_RD),
    .BUS_WR         (BUS_WR),
    .BUS_DATA_OUT   (BUS_DATA_OUT),
    .USB_WRITE      (USB_WRITE),
    .USB_DATA_IN    (USB_DATA_IN),
    .USB_FULL       (USB_FULL),
    .FIFO_READ_NEXT (FIFO_READ_NEXT),
    .FIFO_EMPTY     (FIFO_EMPTY),
    .FIFO_DATA      (FIFO_DATA),
    .FIFO_OVERFLOW  (FIFO_OVERFLOW)
  );

  initial begin
    BUS_CLK = 1'b0;
    forever #5 BUS_CLK = ~BUS_CLK;
  end

  typedef struct {
    string       name;
    logic        rst_n;
    logic        wr;
    logic [7:0]  data;
    logic        pop;
    logic        exp_empty;
    logic        exp_full;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Advance one clock; inputs and outputs are handled 1 time unit after the edge
  task automatic tick();
    @(posedge BUS_CLK);
    #1;
  endtask

  task automatic read_reg(input string name, input logic [15:0] addr,
                          input logic [7:0] expected);
    BUS_ADD = addr;
    BUS_RD  = 1'b1;
    tick();
    BUS_RD  = 1'b0;
    check(name, 32'(BUS_DATA_OUT), 32'(expected));
  endtask

  task automatic send_byte(input logic [7:0] b);
    USB_WRITE   = 1'b1;
    USB_DATA_IN = b;
    tick();
    USB_WRITE   = 1'b0;
  endtask

  // Four bytes on consecutive cycles, optionally popping on the last one
  task automatic send_word(input logic [31:0] w, input logic pop_last);
    USB_WRITE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      USB_DATA_IN    = w[31-8*i -: 8];
      FIFO_READ_NEXT = pop_last && (i == 3);
      tick();
    end
    USB_WRITE      = 1'b0;
    FIFO_READ_NEXT = 1'b0;
  endtask

  task automatic pop_check(input string name, input logic [31:0] expected);
    check({name, "_nonempty"}, 32'(FIFO_EMPTY), 32'd0);
    check(name, FIFO_DATA, expected);
    FIFO_READ_NEXT = 1'b1;
    tick();
    FIFO_READ_NEXT = 1'b0;
  endtask

  initial begin
    BUS_RST_N      = 1'b0;
    BUS_ADD        = 16'h0000;
    BUS_DATA_IN    = 8'h00;
    BUS_RD         = 1'b0;
    BUS_WR         = 1'b0;
    USB_WRITE      = 1'b0;
    USB_DATA_IN    = 8'h00;
    FIFO_READ_NEXT = 1'b0;

    // name, rst_n, wr, data, pop, exp_empty, exp_full, chk_data, exp_data
    vecs[0] = '{"rst_cyc0", 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{"rst_cyc1", 1'b0, 1'b1, 8'hEE, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{"pack_b0",  1'b1, 1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[3] = '{"pack_b1",  1'b1, 1'b1, 8'h34, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[4] = '{"pack_b2",  1'b1, 1'b1, 8'h56, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{"pack_b3",  1'b1, 1'b1, 8'h78, 1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678};

    // Reset with USB_WRITE active, then first word packing
    for (int i = 0; i < 6; i++) begin
      BUS_RST_N      = vecs[i].rst_n;
      USB_WRITE      = vecs[i].wr;
      USB_DATA_IN    = vecs[i].data;
      FIFO_READ_NEXT = vecs[i].pop;
      tick();
      check({vecs[i].name, "_empty"}, 32'(FIFO_EMPTY), 32'(vecs[i].exp_empty));
      check({vecs[i].name, "_full"},  32'(USB_FULL),   32'(vecs[i].exp_full));
      if (vecs[i].chk_data) check({vecs[i].name, "_data"}, FIFO_DATA, vecs[i].exp_data);
      if (i == 1) begin
        check("rst_ovf_flag", 32'(FIFO_OVERFLOW), 32'd0);
        check("rst_bus_out",  32'(BUS_DATA_OUT),  32'd0);
      end
    end
    USB_WRITE = 1'b0;
    read_reg("pack_size0", 16'd1, 8'd1);
    pop_check("pack_pop", 32'h12345678);
    check("pack_empty_after_pop", 32'(FIFO_EMPTY), 32'd1);
    read_reg("pack_size0_after", 16'd1, 8'd0);
    read_reg("pack_bcnt", 16'd5, 8'd0);
    read_reg("unmapped_addr", 16'h0042, 8'h00);

    // Fill to DEPTH, then drop a fifth word
    for (int k = 0; k < 5; k++) begin
      send_word({8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)}, 1'b0);
      if (k == 3) begin
        check("fill_full", 32'(USB_FULL), 32'd1);
        check("fill_no_ovf", 32'(FIFO_OVERFLOW), 32'd0);
      end
    end
    check("ovf_still_full", 32'(USB_FULL), 32'd1);
    check("ovf_flag", 32'(FIFO_OVERFLOW), 32'd1);
    read_reg("ovf_cnt1", 16'd4, 8'd1);
    read_reg("full_size0", 16'd1, 8'd4);
    read_reg("full_size1", 16'd2, 8'd0);
    read_reg("full_size2", 16'd3, 8'd0);
    pop_check("drain_w0", 32'h00010203);
    check("drain_not_full", 32'(USB_FULL), 32'd0);
    pop_check("drain_w1", 32'h04050607);
    pop_check("drain_w2", 32'h08090A0B);
    pop_check("drain_w3", 32'h0C0D0E0F);
    check("drain_empty", 32'(FIFO_EMPTY), 32'd1);

    // Second fill that wraps both pointers
    send_word(32'h20212223, 1'b0);
    send_word(32'h24252627, 1'b0);
    pop_check("wrap_a", 32'h20212223);
    send_word(32'h28292A2B, 1'b0);
    send_word(32'h2C2D2E2F, 1'b0);
    send_word(32'h30313233, 1'b0);
    check("wrap_full", 32'(USB_FULL), 32'd1);
    pop_check("wrap_b", 32'h24252627);
    pop_check("wrap_c", 32'h28292A2B);
    pop_check("wrap_d", 32'h2C2D2E2F);
    pop_check("wrap_e", 32'h30313233);
    check("wrap_empty", 32'(FIFO_EMPTY), 32'd1);

    // Commit coinciding with a pop while full
    send_word(32'h40414243, 1'b0);
    send_word(32'h44454647, 1'b0);
    send_word(32'h48494A4B, 1'b0);
    send_word(32'h4C4D4E4F, 1'b0);
    check("simul_head", FIFO_DATA, 32'h40414243);
    send_word(32'h50515253, 1'b1);
    check("simul_full", 32'(USB_FULL), 32'd1);
    read_reg("simul_size0", 16'd1, 8'd4);
    read_reg("simul_ovf", 16'd4, 8'd1);
    pop_check("simul_w1", 32'h44454647);
    pop_check("simul_w2", 32'h48494A4B);
    pop_check("simul_w3", 32'h4C4D4E4F);
    pop_check("simul_w4", 32'h50515253);
    check("simul_empty", 32'(FIFO_EMPTY), 32'd1);

    // Soft reset in the middle of a word
    send_byte(8'h01);
    send_byte(8'h02);
    read_reg("mid_bcnt", 16'd5, 8'd2);
    BUS_ADD = 16'd0;
    BUS_WR  = 1'b1;
    tick();
    BUS_WR  = 1'b0;
    tick();
    read_reg("srst_bcnt", 16'd5, 8'd0);
    read_reg("srst_ovf", 16'd4, 8'd0);
    check("srst_ovf_flag", 32'(FIFO_OVERFLOW), 32'd0);
    check("srst_empty", 32'(FIFO_EMPTY), 32'd1);
    send_word(32'hAABBCCDD, 1'b0);
    read_reg("srst_size0", 16'd1, 8'd1);
    pop_check("srst_word", 32'hAABBCCDD);

    // Overflow counter saturation
    for (int k = 0; k < 4; k++)
      send_word({8'h60 + 8'(4*k), 8'h61 + 8'(4*k), 8'h62 + 8'(4*k), 8'h63 + 8'(4*k)}, 1'b0);
    send_word(32'hDEADBEEF, 1'b0);
    send_word(32'hDEADBEEF, 1'b0);
    read_reg("ovf_cnt2", 16'd4, 8'd2);
    for (int k = 0; k < 298; k++) send_word(32'hDEADBEEF, 1'b0);
    read_reg("sat_ovf", 16'd4, 8'hFF);
    check("sat_flag", 32'(FIFO_OVERFLOW), 32'd1);
    read_reg("sat_size0", 16'd1, 8'd4);
    pop_check("sat_w0", 32'h60616263);
    pop_check("sat_w1", 32'h64656667);
    pop_check("sat_w2", 32'h68696A6B);
    pop_check("sat_w3", 32'h6C6D6E6F);

    // Pop on empty is harmless
    FIFO_READ_NEXT = 1'b1;
    tick();
    FIFO_READ_NEXT = 1'b0;
    check("empty_pop_empty", 32'(FIFO_EMPTY), 32'd1);
    check("empty_pop_full", 32'(USB_FULL), 32'd0);
    read_reg("empty_pop_size0", 16'd1, 8'd0);
    read_reg("empty_pop_ovf", 16'd4, 8'hFF);
    send_word(32'h01020304, 1'b0);
    pop_check("after_empty_pop", 32'h01020304);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
